// File: rtl/hsm_axil_master.sv
// Single-outstanding AXI4-Lite initiator. One command (read or write) becomes
// one AXI4-Lite transaction, and the initiator returns one response. Every
// output comes straight from a flop.
//
// Handshake rule for all channels (cmd, rsp, AW, W, B, AR, R): a transfer
// happens on a rising edge where VALID and READY are both high. Once VALID is
// raised, it and its payload stay unchanged until that transfer. READY may be
// raised or lowered at any time.
module hsm_axil_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [2:0]                      dbg_state
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_WR_B = 3'd2;
  localparam logic [2:0] ST_RD_A = 3'd3;
  localparam logic [2:0] ST_RD_R = 3'd4;
  localparam logic [2:0] ST_RSP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    resp_q, resp_d;

  // Compute the next state and next register values for each phase of the transaction.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    case (state_q)
      ST_IDLE: begin
        // cmd_ready is low for the first cycle after reset, then rises.
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_d = 1'b0;
          write_d     = cmd_write;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          awvalid_d   = cmd_write;
          wvalid_d    = cmd_write;
          arvalid_d   = ~cmd_write;
          state_d     = cmd_write ? ST_WR : ST_RD_A;
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      ST_WR: begin
        // AW and W retire independently. A retired channel is only raised again in IDLE.
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (M_AXI_BVALID && bready_q) begin
          bready_d    = 1'b0;
          resp_d      = M_AXI_BRESP;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RD_A: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (M_AXI_RVALID && rready_q) begin
          rready_d    = 1'b0;
          rdata_d     = M_AXI_RDATA;
          resp_d      = M_AXI_RRESP;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset abandons any transaction in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = write_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_hsm_axil_master.sv
// Bench for hsm_axil_master: a table of command vectors run against a small
// 4 x 32-bit AXI4-Lite slave model, plus hand-written reset sequences.
module tb_hsm_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot, dbg_state;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b0, rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [4];

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          a_dly;      // cycles before AWREADY/ARREADY
    int          w_dly;      // cycles before WREADY
    int          d_dly;      // cycles before BVALID/RVALID once due
    logic [1:0]  slv_resp;
    int          rsp_dly;    // cycles rsp_ready is held low
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [9];

  hsm_axil_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(4)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready), .dbg_state(dbg_state)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] axi_active();
    return {awvalid, wvalid, arvalid, bready, rready};
  endfunction

  // Drive one command through the DUT, act as the slave, then consume the response.
  task automatic run_txn(input vec_t v, input string name);
    int guard, cyc, aw_n, w_n, b_n, ar_n, r_n, bcnt, rcnt, proto;
    bit done;
    logic [3:0]  cap_addr;
    logic [31:0] cap_data;
    logic [3:0]  cap_strb;
    logic [31:0] held_rdata;
    logic [1:0]  held_resp;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk({name, " cmd_ready timeout"}, 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 0; aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
    bcnt = 0; rcnt = 0; proto = 0; done = 1'b0;
    cap_addr = '0; cap_data = '0; cap_strb = '0;
    while (!done && cyc < 60) begin
      awready = v.wr && (aw_n == 0) && (cyc >= v.a_dly);
      wready  = v.wr && (w_n == 0) && (cyc >= v.w_dly);
      bvalid  = (aw_n > 0) && (w_n > 0) && (bcnt >= v.d_dly);
      bresp   = v.slv_resp;
      arready = !v.wr && (ar_n == 0) && (cyc >= v.a_dly);
      rvalid  = (ar_n > 0) && (rcnt >= v.d_dly);
      rdata   = mem[v.addr[3:2]];
      rresp   = v.slv_resp;
      // Protocol: VALIDs held until their handshake, never re-raised, payload stable.
      if (awvalid != (v.wr && aw_n == 0)) proto++;
      if (wvalid != (v.wr && w_n == 0)) proto++;
      if (arvalid != (!v.wr && ar_n == 0)) proto++;
      if (awvalid && awaddr != v.addr) proto++;
      if (wvalid && (wdata != v.wdata || wstrb != v.wstrb)) proto++;
      if (arvalid && araddr != v.addr) proto++;
      if (cmd_ready || rsp_valid) proto++;
      if (awvalid && awready) begin aw_n++; cap_addr = awaddr; end
      if (wvalid && wready) begin w_n++; cap_data = wdata; cap_strb = wstrb; end
      if (arvalid && arready) ar_n++;
      if (bvalid && bready) begin
        b_n++; done = 1'b1;
        if (v.slv_resp == 2'b00)
          for (int j = 0; j < 4; j++)
            if (cap_strb[j]) mem[cap_addr[3:2]][8*j +: 8] = cap_data[8*j +: 8];
      end
      if (rvalid && rready) begin r_n++; done = 1'b1; end
      if (aw_n > 0 && w_n > 0) bcnt++;
      if (ar_n > 0) rcnt++;
      @(negedge clk);
      cyc++;
    end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
    chk({name, " bus done"}, 32'(done), 32'd1);
    chk({name, " aw count"}, aw_n, v.wr ? 1 : 0);
    chk({name, " w count"}, w_n, v.wr ? 1 : 0);
    chk({name, " b count"}, b_n, v.wr ? 1 : 0);
    chk({name, " ar count"}, ar_n, v.wr ? 0 : 1);
    chk({name, " r count"}, r_n, v.wr ? 0 : 1);
    chk({name, " protocol"}, proto, 0);
    held_rdata = rsp_rdata;
    held_resp  = rsp_resp;
    for (int k = 0; k < v.rsp_dly; k++) begin
      chk({name, " stall rsp_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, " stall cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({name, " stall axi quiet"}, 32'(axi_active()), 32'd0);
      chk({name, " stall rdata stable"}, rsp_rdata, held_rdata);
      chk({name, " stall resp stable"}, 32'(rsp_resp), 32'(held_resp));
      @(negedge clk);
    end
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " rsp_write"}, 32'(rsp_write), 32'(v.wr));
    chk({name, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({name, " rsp_resp"}, 32'(rsp_resp), 32'(v.exp_resp));
    chk({name, " axi quiet in rsp"}, 32'(axi_active()), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
    chk({name, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    vec_t fin;
    int stale;
    mem[0] = 32'h0; mem[1] = 32'h0; mem[2] = 32'h0; mem[3] = 32'h12345678;
    //            wr    addr   wdata         strb  a  w  d  slv    rsp  exp_rdata     exp_resp
    vecs[0] = '{1'b1, 4'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 32'h00000000, 2'b00};
    vecs[1] = '{1'b1, 4'h0, 32'h11223344, 4'hF, 0, 3, 0, 2'b00, 0, 32'h00000000, 2'b00};
    vecs[2] = '{1'b0, 4'hC, 32'h0,        4'h0, 0, 0, 2, 2'b00, 0, 32'h12345678, 2'b00};
    vecs[3] = '{1'b1, 4'h4, 32'hCAFEF00D, 4'hF, 0, 0, 1, 2'b10, 5, 32'h00000000, 2'b10};
    vecs[4] = '{1'b1, 4'h4, 32'hA5A5A5A5, 4'hF, 2, 0, 0, 2'b00, 0, 32'h00000000, 2'b00};
    vecs[5] = '{1'b0, 4'h4, 32'h0,        4'h0, 0, 0, 0, 2'b00, 0, 32'hA5A5A5A5, 2'b00};
    vecs[6] = '{1'b1, 4'h8, 32'h00005555, 4'h3, 1, 1, 0, 2'b00, 0, 32'h00000000, 2'b00};
    vecs[7] = '{1'b0, 4'h8, 32'h0,        4'h0, 2, 0, 1, 2'b00, 2, 32'hDEAD5555, 2'b00};
    vecs[8] = '{1'b0, 4'h0, 32'h0,        4'h0, 0, 0, 0, 2'b11, 1, 32'h11223344, 2'b11};

    // Reset values, checked while reset is held across clock edges.
    @(negedge clk);
    #2;
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset axi quiet", 32'(axi_active()), 32'd0);
    chk("reset awaddr", 32'(awaddr), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset prot", 32'({awprot, arprot}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset cmd_ready low", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("first edge cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while AWVALID is high and the slave never accepts.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC;
    cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("abort awvalid up", 32'(awvalid), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort valids cleared", 32'(axi_active()), 32'd0);
    chk("abort cmd_ready low", 32'(cmd_ready), 32'd0);
    chk("abort rsp_valid low", 32'(rsp_valid), 32'd0);
    chk("abort awaddr cleared", 32'(awaddr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort cmd_ready after release", 32'(cmd_ready), 32'd1);
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid || axi_active() != 5'd0) stale++;
    end
    chk("abort no stale activity", stale, 0);

    // The abandoned write must not have reached the slave; addr 0xC keeps its value.
    fin = '{1'b0, 4'hC, 32'h0, 4'h0, 1, 0, 1, 2'b00, 0, 32'h12345678, 2'b00};
    run_txn(fin, "after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
